// File: rtl/paddle_ctrl_if.sv
// paddle_ctrl_if: groups the game-side control inputs, the pixel tile
// counters and the paddle outputs into one bundle. The master side (game
// logic / video timing) drives the inputs; the slave side is the paddle.
interface paddle_ctrl_if;
    logic       game_active;
    logic       iup;
    logic       idown;
    logic [5:0] icolcount;
    logic [5:0] irowcount;
    logic [5:0] iballrow;
    logic       odrawpaddle;
    logic [5:0] opaddley;

    modport master (
        output game_active, iup, idown, icolcount, irowcount, iballrow,
        input  odrawpaddle, opaddley
    );

    modport slave (
        input  game_active, iup, idown, icolcount, irowcount, iballrow,
        output odrawpaddle, opaddley
    );
endinterface

// File: rtl/paddle_ctrl.sv
// PaddleCtrl: player paddle for the 40x30 tile field. Two raw buttons are
// synchronised and debounced, the paddle row steps once per move period,
// and a registered draw flag is produced from the tile column/row counts.
// Optional feature macro: PADDLE_AUTO_EN -- when defined the paddle tracks
// the ball row instead of the buttons (debouncers remain but are unused).
module paddle_ctrl #(
    parameter int GAME_WIDTH      = 40,
    parameter int GAME_HEIGHT     = 30,
    parameter int PADDLE_COL      = 0,
    parameter int PADDLE_HEIGHT   = 6,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int MOVE_DIV        = 1250000
) (
    input  logic          clock,
    input  logic          rst_n,
    paddle_ctrl_if.slave  bus
);

    localparam int CENTRE = (GAME_HEIGHT - PADDLE_HEIGHT) / 2;
    localparam int YMAX   = GAME_HEIGHT - PADDLE_HEIGHT;
    localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int MOVE_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    localparam logic [5:0]        CENTRE_Y  = 6'(CENTRE);
    localparam logic [5:0]        YMAX_Y    = 6'(YMAX);
    localparam logic [5:0]        COL_Y     = 6'(PADDLE_COL);
    localparam logic [6:0]        GW7       = 7'(GAME_WIDTH);
    localparam logic [6:0]        GH7       = 7'(GAME_HEIGHT);
    localparam logic [6:0]        PH7       = 7'(PADDLE_HEIGHT);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [MOVE_W-1:0] MOVE_LAST = MOVE_W'(MOVE_DIV - 1);

    typedef enum logic {
        HOLD,
        PLAY
    } state_t;

    state_t              state_q;
    logic [5:0]          paddleY_q;
    logic                draw_q;
    logic [MOVE_W-1:0]   moveCnt_q;

    // Index 0 is the up button, index 1 the down button.
    logic [1:0]          rawBtn;
    logic [1:0]          sync1_q;
    logic [1:0]          sync2_q;
    logic [1:0]          level_q;
    logic [1:0]          level_d;
    logic [DEB_W-1:0]    debCnt_q [2];
    logic [DEB_W-1:0]    debCnt_d [2];

    logic                stepTick;
    logic                moveUp;
    logic                moveDown;
    logic                colHit;
    logic                rowHit;

    assign rawBtn   = {bus.idown, bus.iup};
    assign stepTick = (moveCnt_q == MOVE_LAST);

    // Debounce: a button's accepted level only flips after the synchronised
    // input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < 2; i++) begin
            debCnt_d[i] = debCnt_q[i];
            if (sync2_q[i] == level_q[i]) begin
                debCnt_d[i] = '0;
            end else if (debCnt_q[i] == DEB_LAST) begin
                level_d[i]  = sync2_q[i];
                debCnt_d[i] = '0;
            end else begin
                debCnt_d[i] = debCnt_q[i] + DEB_W'(1);
            end
        end
    end

    // Two-flop synchronisers and the debounce registers.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_q     <= '0;
            debCnt_q[0] <= '0;
            debCnt_q[1] <= '0;
        end else begin
            sync1_q     <= rawBtn;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            debCnt_q[0] <= debCnt_d[0];
            debCnt_q[1] <= debCnt_d[1];
        end
    end

`ifdef PADDLE_AUTO_EN
    logic signed [6:0] tgtRaw;
    logic [5:0]        target;
    logic              unusedLevels;

    assign unusedLevels = ^level_q;
    assign tgtRaw = $signed({1'b0, bus.iballrow}) - $signed(7'(PADDLE_HEIGHT / 2));

    // Target row centres the paddle on the ball, clamped to the legal range.
    always_comb begin
        if (tgtRaw[6]) begin
            target = '0;
        end else if (tgtRaw > $signed(7'(YMAX))) begin
            target = YMAX_Y;
        end else begin
            target = tgtRaw[5:0];
        end
        moveUp   = (paddleY_q > target);
        moveDown = (paddleY_q < target);
    end
`else
    logic unusedBallRow;

    assign unusedBallRow = ^bus.iballrow;

    // Exactly one pressed button requests a move; both or neither cancel out.
    always_comb begin
        moveUp   = level_q[0] & ~level_q[1];
        moveDown = level_q[1] & ~level_q[0];
    end
`endif

    // Hold/play state machine with the move-rate counter and paddle row.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q   <= HOLD;
            paddleY_q <= CENTRE_Y;
            moveCnt_q <= '0;
        end else begin
            case (state_q)
                HOLD: begin
                    paddleY_q <= CENTRE_Y;
                    moveCnt_q <= '0;
                    if (bus.game_active) begin
                        state_q <= PLAY;
                    end
                end
                PLAY: begin
                    if (!bus.game_active) begin
                        state_q   <= HOLD;
                        paddleY_q <= CENTRE_Y;
                        moveCnt_q <= '0;
                    end else begin
                        moveCnt_q <= stepTick ? '0 : moveCnt_q + MOVE_W'(1);
                        if (stepTick) begin
                            if (moveUp && (paddleY_q != 6'd0)) begin
                                paddleY_q <= paddleY_q - 6'd1;
                            end else if (moveDown && (paddleY_q < YMAX_Y)) begin
                                paddleY_q <= paddleY_q + 6'd1;
                            end
                        end
                    end
                end
                default: begin
                    state_q   <= HOLD;
                    paddleY_q <= CENTRE_Y;
                    moveCnt_q <= '0;
                end
            endcase
        end
    end

    // Pixel hit test in 7 bits so paddle bottom never wraps; off-field counts miss.
    always_comb begin
        colHit = (bus.icolcount == COL_Y) && ({1'b0, bus.icolcount} < GW7);
        rowHit = ({1'b0, bus.irowcount} < GH7) &&
                 ({1'b0, bus.irowcount} >= {1'b0, paddleY_q}) &&
                 ({1'b0, bus.irowcount} < ({1'b0, paddleY_q} + PH7));
    end

    // Registered draw flag, one clock behind the tile counters.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            draw_q <= 1'b0;
        end else begin
            draw_q <= colHit && rowHit;
        end
    end

    assign bus.opaddley    = paddleY_q;
    assign bus.odrawpaddle = draw_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// TbPaddleCtrl: scoreboard bench for paddle_ctrl. A reference model derives,
// from the input history, the paddle row and draw flag expected after every
// clock edge and queues them; a monitor pops and compares on the falling edge.
module tb_paddle_ctrl;

    localparam int DEB    = 4;
    localparam int MDIV   = 8;
    localparam int PH     = 6;
    localparam int CENTRE = 12;
    localparam int YMAX   = 24;

    typedef struct {
        logic [5:0] pos;
        logic       draw;
    } exp_t;

    logic clock = 1'b0;
    logic rst_n = 1'b0;

    paddle_ctrl_if bus ();

    paddle_ctrl #(
        .GAME_WIDTH      (40),
        .GAME_HEIGHT     (30),
        .PADDLE_COL      (0),
        .PADDLE_HEIGHT   (PH),
        .DEBOUNCE_CYCLES (DEB),
        .MOVE_DIV        (MDIV)
    ) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    exp_t expQ [$];
    int   checks = 0;
    int   passes = 0;

    // Reference model state: row, playing flag, edges spent playing,
    // accepted button levels and the last six raw samples of each button.
    int mPos   = CENTRE;
    int mPlay  = 0;
    int mPlayN = 0;
    int mUp    = 0;
    int mDown  = 0;
    int upHist [6];
    int dnHist [6];

    task automatic checkOutput(input string name, input logic [5:0] act, input logic [5:0] req);
        checks++;
        if (act === req) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    // A level flips once the input seen through the two sync flops has shown
    // the opposite value for DEB consecutive samples.
    function automatic int debounced(input int level, input int hist [6]);
        for (int i = 2; i < 2 + DEB; i++) begin
            if (hist[i] == level) return level;
        end
        return 1 - level;
    endfunction

    // Reference model: evaluated on each rising edge, pushes the post-edge state.
    always @(posedge clock) begin : refModel
        exp_t e;
        int   col;
        int   row;
        int   tgt;
        if (!rst_n) begin
            mPos   = CENTRE;
            mPlay  = 0;
            mPlayN = 0;
            mUp    = 0;
            mDown  = 0;
            for (int i = 0; i < 6; i++) begin
                upHist[i] = 0;
                dnHist[i] = 0;
            end
            e.draw = 1'b0;
        end else begin
            col = int'(bus.icolcount);
            row = int'(bus.irowcount);
            e.draw = (col == 0) && (row < 30) && (row >= mPos) && (row < mPos + PH);
            if (mPlay == 0) begin
                mPos   = CENTRE;
                mPlayN = 0;
                if (bus.game_active) mPlay = 1;
            end else if (!bus.game_active) begin
                mPlay  = 0;
                mPos   = CENTRE;
                mPlayN = 0;
            end else begin
                if ((mPlayN % MDIV) == MDIV - 1) begin
`ifdef PADDLE_AUTO_EN
                    tgt = int'(bus.iballrow) - PH / 2;
                    if (tgt < 0) tgt = 0;
                    if (tgt > YMAX) tgt = YMAX;
                    if (mPos > tgt) mPos--;
                    else if (mPos < tgt) mPos++;
`else
                    tgt = 0;
                    if (mUp == 1 && mDown == 0 && mPos > 0) mPos--;
                    else if (mDown == 1 && mUp == 0 && mPos < YMAX) mPos++;
`endif
                end
                mPlayN++;
            end
            for (int i = 5; i > 0; i--) begin
                upHist[i] = upHist[i-1];
                dnHist[i] = dnHist[i-1];
            end
            upHist[0] = bus.iup ? 1 : 0;
            dnHist[0] = bus.idown ? 1 : 0;
            mUp   = debounced(mUp, upHist);
            mDown = debounced(mDown, dnHist);
        end
        e.pos = 6'(mPos);
        expQ.push_back(e);
    end

    // Monitor: compares DUT outputs with the queued expectation on the falling edge.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("sbPaddleY", bus.opaddley, e.pos);
            checkOutput("sbDraw", {5'b0, bus.odrawpaddle}, {5'b0, e.draw});
        end
    end

    task automatic applyStimulus(input logic ga, input logic up, input logic dn, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            bus.game_active = ga;
            bus.iup         = up;
            bus.idown       = dn;
            bus.icolcount   = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
            bus.irowcount   = 6'($urandom_range(0, 63));
            bus.iballrow    = 6'($urandom_range(0, 63));
        end
    endtask

    task automatic doReset(input int cycles);
        @(negedge clock);
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, cycles);
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    initial begin : stimulus
        int waited;
        int upLeft;
        int dnLeft;
        logic [5:0] prevRow;
        logic [5:0] prevCol;
        bus.game_active = 1'b1;
        bus.iup         = 1'b0;
        bus.idown       = 1'b0;
        bus.icolcount   = 6'd0;
        bus.irowcount   = 6'd0;
        bus.iballrow    = 6'd0;

        // Reset held three cycles with play requested.
        applyStimulus(1'b1, 1'b0, 1'b0, 3);
        @(negedge clock);
        checkOutput("resetPaddleY", bus.opaddley, 6'd12);
        checkOutput("resetDraw", {5'b0, bus.odrawpaddle}, 6'd0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 4);
        checkOutput("centreAfterReset", bus.opaddley, 6'd12);

`ifndef PADDLE_AUTO_EN
        // Up held: walks to 0 and stays there.
        applyStimulus(1'b1, 1'b1, 1'b0, 40);
        applyStimulus(1'b1, 1'b1, 1'b0, 100);
        checkOutput("upSaturate", bus.opaddley, 6'd0);

        // Short down glitch is rejected; long press walks to YMAX.
        applyStimulus(1'b1, 1'b0, 1'b1, 2);
        applyStimulus(1'b1, 1'b0, 1'b0, 20);
        checkOutput("glitchIgnored", bus.opaddley, 6'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 250);
        checkOutput("downSaturate", bus.opaddley, 6'd24);

        // Both buttons cancel.
        applyStimulus(1'b1, 1'b1, 1'b1, 64);
        checkOutput("bothHeld", bus.opaddley, 6'd24);
        applyStimulus(1'b1, 1'b0, 1'b0, 20);
`endif

        // Draw sweep at the centre position: column 0 then column 1.
        doReset(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 4);
        prevCol = 6'd0;
        prevRow = 6'd0;
        for (int i = 0; i <= 128; i++) begin
            @(negedge clock);
            if (i > 0) begin
                checkOutput("sweepDraw", {5'b0, bus.odrawpaddle},
                            {5'b0, (prevCol == 6'd0) && (prevRow >= 6'd12) && (prevRow <= 6'd17)});
            end
            prevCol = (i < 64) ? 6'd0 : 6'd1;
            prevRow = 6'(i % 64);
            bus.icolcount = prevCol;
            bus.irowcount = prevRow;
        end

`ifndef PADDLE_AUTO_EN
        // Walk to row 20, then drop play: snaps to centre and ignores buttons.
        doReset(2);
        waited = 0;
        while (mPos != 20 && waited < 200) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1);
            waited++;
        end
        checkOutput("reach20", bus.opaddley, 6'd20);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        @(negedge clock);
        checkOutput("holdCentre", bus.opaddley, 6'd12);
        applyStimulus(1'b0, 1'b1, 1'b0, 40);
        checkOutput("holdIgnoresButtons", bus.opaddley, 6'd12);
`else
        // Auto tracking toward a ball at row 25 settles at 22.
        doReset(2);
        for (int i = 0; i < 120; i++) begin
            @(negedge clock);
            bus.iballrow = 6'd25;
        end
        checkOutput("autoTarget", bus.opaddley, 6'd22);
`endif

        // Randomised phase: buttons held for random lengths, rare play/reset toggles.
        upLeft = 0;
        dnLeft = 0;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clock);
            if (upLeft == 0) begin
                bus.iup = 1'($urandom_range(0, 1));
                upLeft  = int'($urandom_range(1, 14));
            end
            if (dnLeft == 0) begin
                bus.idown = 1'($urandom_range(0, 1));
                dnLeft    = int'($urandom_range(1, 14));
            end
            upLeft--;
            dnLeft--;
            if (bus.game_active && $urandom_range(0, 199) == 0) bus.game_active = 1'b0;
            else if (!bus.game_active && $urandom_range(0, 7) == 0) bus.game_active = 1'b1;
            rst_n         = ($urandom_range(0, 499) != 0);
            bus.icolcount = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
            bus.irowcount = 6'($urandom_range(0, 63));
            bus.iballrow  = 6'($urandom_range(0, 63));
        end
        @(negedge clock);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
